// File: rtl/servo_pkg.sv
// Shared constants and types for the sorter servo command sequencer.
package servo_pkg;

    localparam int unsigned NUM_SERVOS = 5;

    localparam int unsigned POS_LOW  = 160;
    localparam int unsigned POS_MID  = 355;
    localparam int unsigned POS_HIGH = 800;

    localparam int unsigned RED_BLUE    = 0;
    localparam int unsigned GREEN_OTHER = 1;
    localparam int unsigned BIN_RECYCLE = 2;
    localparam int unsigned RED         = 3;
    localparam int unsigned GREEN_BLUE  = 4;

    typedef enum logic [1:0] {
        POS_CODE_LOW     = 2'd0,
        POS_CODE_MID     = 2'd1,
        POS_CODE_HIGH    = 2'd2,
        POS_CODE_RELEASE = 2'd3
    } posCode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } seqState_t;

endpackage

// File: rtl/servo_arb2.sv
// Two-requester grant logic: fixed sort priority, or round-robin when
// SERVO_SEQ_RR_EN is defined.
module servo_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic sortReq,
    input  logic maintReq,
    input  logic accept,
    output logic grantSort,
    output logic grantMaint
);

`ifdef SERVO_SEQ_RR_EN
    logic lastMaint;

    // Resets to "maint served last" so sort wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastMaint <= 1'b1;
        end else if (accept) begin
            lastMaint <= grantMaint;
        end
    end

    always_comb begin
        grantSort  = sortReq && (!maintReq || lastMaint);
        grantMaint = maintReq && (!sortReq || !lastMaint);
    end
`else
    logic unusedArb;
    assign unusedArb = ^{clk, rst, accept};

    always_comb begin
        grantSort  = sortReq;
        grantMaint = maintReq && !sortReq;
    end
`endif

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Arbitrates sort/maintenance servo move commands, drives servo select/position
// registers and signals completion after a settle time. Optional: SERVO_SEQ_RR_EN.
module servo_cmd_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 25000000,
    parameter int unsigned POS_W         = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sort_valid,
    input  logic [2:0]                  sort_servo,
    input  logic [1:0]                  sort_pos,
    output logic                        sort_ready,
    output logic                        sort_done,
    input  logic                        maint_valid,
    input  logic [2:0]                  maint_servo,
    input  logic [1:0]                  maint_pos,
    output logic                        maint_ready,
    output logic                        maint_done,
    output logic [NUM_SERVOS-1:0]       servo_sel,
    output logic [NUM_SERVOS*POS_W-1:0] servo_pos,
    output logic                        busy,
    output logic                        cmd_err
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seqState_t                  state, stateNext;
    logic [CNT_W-1:0]           cnt, cntNext;
    logic [NUM_SERVOS-1:0]      selQ, selNext;
    logic [NUM_SERVOS*POS_W-1:0] posQ, posNext;
    logic                       reqMaintQ, reqMaintNext;
    logic                       sortDoneQ, sortDoneNext;
    logic                       maintDoneQ, maintDoneNext;
    logic                       errQ, errNext;
    logic                       busyQ;

    logic                       grantSort, grantMaint;
    logic                       canAccept, accept;
    logic [2:0]                 cmdServo;
    posCode_t                   cmdCode;
    logic [POS_W-1:0]           codePos;

    servo_arb2 uArb (
        .clk        (clk),
        .rst        (rst),
        .sortReq    (sort_valid),
        .maintReq   (maint_valid),
        .accept     (accept),
        .grantSort  (grantSort),
        .grantMaint (grantMaint)
    );

    assign canAccept   = (state == IDLE) && !rst;
    assign sort_ready  = canAccept && grantSort;
    assign maint_ready = canAccept && grantMaint;
    assign accept      = sort_ready || maint_ready;

    assign cmdServo = grantMaint ? maint_servo : sort_servo;
    assign cmdCode  = posCode_t'(grantMaint ? maint_pos : sort_pos);

    always_comb begin
        codePos = POS_W'(POS_MID);
        case (cmdCode)
            POS_CODE_LOW:  codePos = POS_W'(POS_LOW);
            POS_CODE_HIGH: codePos = POS_W'(POS_HIGH);
            default:       codePos = POS_W'(POS_MID);
        endcase
    end

    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        selNext       = selQ;
        posNext       = posQ;
        reqMaintNext  = reqMaintQ;
        errNext       = 1'b0;
        sortDoneNext  = 1'b0;
        maintDoneNext = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    reqMaintNext = grantMaint;
                    if (cmdServo >= 3'(NUM_SERVOS)) begin
                        errNext   = 1'b1;
                        stateNext = DONE;
                    end else if (cmdCode == POS_CODE_RELEASE) begin
                        selNext[cmdServo] = 1'b0;
                        stateNext         = DONE;
                    end else begin
                        selNext[cmdServo]                   = 1'b1;
                        posNext[POS_W*cmdServo +: POS_W]    = codePos;
                        stateNext                           = MOVE;
                    end
                end
            end
            MOVE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cntNext   = '0;
                    stateNext = DONE;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Done is registered so it lands exactly in the DONE cycle.
        if (stateNext == DONE) begin
            sortDoneNext  = !reqMaintNext;
            maintDoneNext = reqMaintNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            selQ       <= '0;
            posQ       <= {NUM_SERVOS{POS_W'(POS_MID)}};
            reqMaintQ  <= 1'b0;
            sortDoneQ  <= 1'b0;
            maintDoneQ <= 1'b0;
            errQ       <= 1'b0;
            busyQ      <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            selQ       <= selNext;
            posQ       <= posNext;
            reqMaintQ  <= reqMaintNext;
            sortDoneQ  <= sortDoneNext;
            maintDoneQ <= maintDoneNext;
            errQ       <= errNext;
            busyQ      <= (stateNext != IDLE);
        end
    end

    assign servo_sel  = selQ;
    assign servo_pos  = posQ;
    assign sort_done  = sortDoneQ;
    assign maint_done = maintDoneQ;
    assign cmd_err    = errQ;
    assign busy       = busyQ;

endmodule
